// File: rtl/pe_sequencer.sv
// Control sequencer for a row of PE multiply-accumulate cells: weight load, pixel stream, drain.
// Optional stride-2 window decimation is enabled by defining PESEQ_STRIDE2_EN.
module pe_sequencer #(
    parameter int KSIZE       = 3,
    parameter int IMG_W       = 8,
    parameter int IMG_H       = 8,
    parameter int CNT_WIDTH   = 8,
    parameter int WADDR_WIDTH = 4,
    parameter int PIPE_LAT    = 3
) (
    input  logic                   PESEQ_Clk,
    input  logic                   PESEQ_Reset,
    input  logic                   PESEQ_Start,
    input  logic                   PESEQ_W_Valid,
    input  logic                   PESEQ_Px_Valid,
    input  logic                   PESEQ_Out_Ready,
    output logic                   PESEQ_W_Load,
    output logic [WADDR_WIDTH-1:0] PESEQ_W_Addr,
    output logic                   PESEQ_Px_Ready,
    output logic                   PESEQ_Pe_Clear,
    output logic                   PESEQ_Out_Reg_Set,
    output logic                   PESEQ_Fifo_Set,
    output logic                   PESEQ_Out_Valid,
    output logic                   PESEQ_Done
);

    localparam int FLUSH_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

    localparam logic [WADDR_WIDTH-1:0] W_LAST     = WADDR_WIDTH'(KSIZE * KSIZE - 1);
    localparam logic [CNT_WIDTH-1:0]   COL_LAST   = CNT_WIDTH'(IMG_W - 1);
    localparam logic [CNT_WIDTH-1:0]   ROW_LAST   = CNT_WIDTH'(IMG_H - 1);
    localparam logic [CNT_WIDTH-1:0]   K_M1       = CNT_WIDTH'(KSIZE - 1);
    localparam logic [FLUSH_W-1:0]     FLUSH_LAST = FLUSH_W'(PIPE_LAT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_LOAD_W,
        ST_STREAM,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t state, state_nxt;

    logic [WADDR_WIDTH-1:0] w_addr;
    logic [CNT_WIDTH-1:0]   row, col;
    logic [FLUSH_W-1:0]     flush_cnt;
    logic [PIPE_LAT-1:0]    tag_pipe;

    logic out_valid, stall, advance, w_load, px_ready, pe_clear, fifo_set, done;
    logic in_window, tag_in, last_px, shift_in;

    assign out_valid = tag_pipe[PIPE_LAT-1];
    assign stall     = out_valid & ~PESEQ_Out_Ready;
    assign last_px   = (row == ROW_LAST) && (col == COL_LAST);
    assign in_window = (row >= K_M1) && (col >= K_M1);

`ifdef PESEQ_STRIDE2_EN
    // Offset from the first full window must be even in both axes.
    assign tag_in = in_window && (row[0] == K_M1[0]) && (col[0] == K_M1[0]);
`else
    assign tag_in = in_window;
`endif

    // Flush beats push a zero tag so the pipe empties behind the last pixel.
    assign shift_in = (state == ST_STREAM) & tag_in;

    always_ff @(posedge PESEQ_Clk) begin
        if (!PESEQ_Reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        w_load    = 1'b0;
        px_ready  = 1'b0;
        pe_clear  = 1'b0;
        advance   = 1'b0;
        fifo_set  = 1'b0;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (PESEQ_Start) state_nxt = ST_CLEAR;
            end
            ST_CLEAR: begin
                pe_clear  = 1'b1;
                state_nxt = ST_LOAD_W;
            end
            ST_LOAD_W: begin
                w_load = PESEQ_W_Valid;
                if (PESEQ_W_Valid && (w_addr == W_LAST)) state_nxt = ST_STREAM;
            end
            ST_STREAM: begin
                px_ready = ~stall;
                advance  = PESEQ_Px_Valid & ~stall;
                fifo_set = advance & (col == COL_LAST);
                if (advance && last_px) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                advance = ~stall;
                if (advance && (flush_cnt == FLUSH_LAST)) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge PESEQ_Clk) begin
        if (!PESEQ_Reset) begin
            w_addr    <= '0;
            row       <= '0;
            col       <= '0;
            flush_cnt <= '0;
            tag_pipe  <= '0;
        end else begin
            if (w_load) begin
                w_addr <= (w_addr == W_LAST) ? '0 : w_addr + 1'b1;
            end
            if (advance) begin
                tag_pipe <= (tag_pipe << 1) | PIPE_LAT'(shift_in);
            end
            if (advance && (state == ST_STREAM)) begin
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= last_px ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
            if (advance && (state == ST_DRAIN)) begin
                flush_cnt <= (flush_cnt == FLUSH_LAST) ? '0 : flush_cnt + 1'b1;
            end
        end
    end

    assign PESEQ_W_Load      = w_load;
    assign PESEQ_W_Addr      = w_addr;
    assign PESEQ_Px_Ready    = px_ready;
    assign PESEQ_Pe_Clear    = pe_clear;
    assign PESEQ_Out_Reg_Set = advance;
    assign PESEQ_Fifo_Set    = fifo_set;
    assign PESEQ_Out_Valid   = out_valid;
    assign PESEQ_Done        = done;

endmodule

// File: tb/tb_pe_sequencer.sv
// Directed bench for pe_sequencer (K=3, 5x5 map, PIPE_LAT=3) with a frame-level reference model.
module tb_pe_sequencer;

    localparam int K  = 3;
    localparam int W  = 5;
    localparam int H  = 5;
    localparam int PL = 3;
`ifdef PESEQ_STRIDE2_EN
    localparam int EXP_OUT = 4;
`else
    localparam int EXP_OUT = 9;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       w_valid = 1'b0;
    logic       px_valid = 1'b0;
    logic       out_ready = 1'b1;
    logic       w_load, px_ready, pe_clear, out_reg_set, fifo_set, out_valid, done;
    logic [3:0] w_addr;

    pe_sequencer #(
        .KSIZE(K), .IMG_W(W), .IMG_H(H), .CNT_WIDTH(8), .WADDR_WIDTH(4), .PIPE_LAT(PL)
    ) dut (
        .PESEQ_Clk(clk), .PESEQ_Reset(rst_n), .PESEQ_Start(start),
        .PESEQ_W_Valid(w_valid), .PESEQ_Px_Valid(px_valid), .PESEQ_Out_Ready(out_ready),
        .PESEQ_W_Load(w_load), .PESEQ_W_Addr(w_addr), .PESEQ_Px_Ready(px_ready),
        .PESEQ_Pe_Clear(pe_clear), .PESEQ_Out_Reg_Set(out_reg_set), .PESEQ_Fifo_Set(fifo_set),
        .PESEQ_Out_Valid(out_valid), .PESEQ_Done(done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    // Frame-level model: phase plus progress counts; the pipe is a queue of window end indices (-1 = none).
    int m_phase = 0;   // 0 idle, 1 clear, 2 weights, 3 pixels, 4 flush, 5 done
    int m_w = 0;
    int m_px = 0;
    int m_fl = 0;
    int m_q[$];
    int win_log[$];

    int f_taken, f_first, f_dones, f_wl, f_stalls;

    function automatic int win_tag(input int p);
        int r, c;
        bit ok;
        r  = p / W;
        c  = p % W;
        ok = (r >= K - 1) && (c >= K - 1);
`ifdef PESEQ_STRIDE2_EN
        ok = ok && ((r - (K - 1)) % 2 == 0) && ((c - (K - 1)) % 2 == 0);
`endif
        return ok ? p : -1;
    endfunction

    function automatic int dut_vec();
        return {21'b0, w_load, w_addr, px_ready, pe_clear, out_reg_set, fifo_set, out_valid, done};
    endfunction

    task automatic check(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, got, exp);
        end
    endtask

    task automatic push_tag(input int t);
        m_q.push_back(t);
        if (m_q.size() > PL) void'(m_q.pop_front());
    endtask

    task automatic model_cycle();
        bit ov, stall, pxr, adv;
        int exp_v;
        ov    = (m_q.size() == PL) && (m_q[0] >= 0);
        stall = ov && !out_ready;
        pxr   = (m_phase == 3) && !stall;
        adv   = (m_phase == 3) ? (px_valid && pxr) : (m_phase == 4) ? !stall : 1'b0;
        exp_v = {21'b0, 1'(m_phase == 2 && w_valid), 4'(m_phase == 2 ? m_w : 0), pxr,
                 1'(m_phase == 1), adv, 1'(m_phase == 3 && adv && (m_px % W == W - 1)),
                 ov, 1'(m_phase == 5)};
        check("outputs{wl,wa,pxr,clr,ors,fifo,ov,done}", dut_vec(), exp_v);
        if (ov && out_ready) win_log.push_back(m_q[0]);
        if (!rst_n) begin
            m_phase = 0; m_w = 0; m_px = 0; m_fl = 0;
            m_q.delete();
        end else begin
            case (m_phase)
                0: if (start) m_phase = 1;
                1: begin m_phase = 2; m_w = 0; end
                2: if (w_valid) begin
                       if (m_w == K * K - 1) begin m_phase = 3; m_w = 0; m_px = 0; end
                       else m_w++;
                   end
                3: if (adv) begin
                       push_tag(win_tag(m_px));
                       m_px++;
                       if (m_px == W * H) begin m_phase = 4; m_fl = 0; end
                   end
                4: if (adv) begin
                       push_tag(-1);
                       m_fl++;
                       if (m_fl == PL) m_phase = 5;
                   end
                default: m_phase = 0;
            endcase
        end
    endtask

    task automatic to_neg();
        @(negedge clk);
        model_cycle();
    endtask

    task automatic to_drive();
        @(posedge clk);
        #1;
    endtask

    // One frame from Start to Done; optional back-pressure, Start/W_Valid glitches, or reset after abort_at pixels.
    task automatic run_frame(input bit do_stall, input bit do_glitch, input int abort_at);
        int acc = 0;
        int n = 0;
        int stall_left = 0;
        bit armed = 1'b0;
        bit fin = 1'b0;
        f_taken = 0; f_first = -1; f_dones = 0; f_wl = 0; f_stalls = 0;
        start = 1'b1; w_valid = 1'b1; px_valid = 1'b1; out_ready = 1'b1;
        while (!fin && n < 400) begin
            to_neg();
            n++;
            if (w_load) begin
                check("w_addr_seq", int'(w_addr), f_wl);
                f_wl++;
            end
            if (out_valid && f_first < 0) f_first = acc;
            if (px_valid && px_ready) acc++;
            if (out_valid && out_ready) f_taken++;
            if (done) begin f_dones++; fin = 1'b1; end
            if (stall_left > 0 && out_valid) begin
                check("stall_px_ready", int'(px_ready), 0);
                check("stall_out_reg_set", int'(out_reg_set), 0);
                stall_left--;
                f_stalls++;
            end
            to_drive();
            start = do_glitch && ((f_wl == 4) || (acc == 6));
            if (do_glitch) w_valid = (n % 3 != 1);
            if (do_stall && !armed && acc >= 12) begin stall_left = 4; armed = 1'b1; end
            out_ready = (stall_left == 0);
            if (abort_at > 0 && acc >= abort_at) begin
                px_valid = 1'b0; start = 1'b0; rst_n = 1'b0;
                to_neg();
                to_drive();
                rst_n = 1'b1;
                to_neg();
                check("post_reset_outputs", dut_vec(), 0);
                to_drive();
                w_valid = 1'b0; out_ready = 1'b1;
                return;
            end
        end
        if (!fin) begin
            n_cmp++;
            n_fail++;
            $display("FAIL frame_timeout: no Done within %0d cycles", n);
        end
        start = 1'b0; w_valid = 1'b0; px_valid = 1'b0; out_ready = 1'b1;
    endtask

    initial begin
        int base;
`ifdef PESEQ_STRIDE2_EN
        int exp_win[$] = '{12, 14, 22, 24};
`else
        int exp_win[$] = '{12, 13, 14, 17, 18, 19, 22, 23, 24};
`endif
        rst_n = 1'b0;
        to_drive();
        to_neg();
        check("reset_outputs", dut_vec(), 0);
        to_drive();
        rst_n = 1'b1;
        to_neg();
        to_drive();

        // Plain frame, weights and pixels back-to-back
        base = win_log.size();
        run_frame(1'b0, 1'b0, 0);
        check("a_weight_loads", f_wl, 9);
        check("a_outputs", f_taken, EXP_OUT);
        check("a_done_pulses", f_dones, 1);
        check("a_first_valid_px", f_first, 15);
        check("a_window_count", win_log.size() - base, exp_win.size());
        foreach (exp_win[i]) begin
            if (base + i < win_log.size()) check("a_window_pos", win_log[base + i], exp_win[i]);
        end
        to_neg();
        check("a_idle_after_done", dut_vec(), 0);
        to_drive();

        // Back-pressure, W_Valid gaps and stray Start pulses
        run_frame(1'b1, 1'b1, 0);
        check("b_weight_loads", f_wl, 9);
        check("b_outputs", f_taken, EXP_OUT);
        check("b_done_pulses", f_dones, 1);
        check("b_stall_cycles", f_stalls, 4);

        // Reset after 10 pixels, then a clean frame
        run_frame(1'b0, 1'b0, 10);
        check("c_done_pulses", f_dones, 0);
        run_frame(1'b0, 1'b0, 0);
        check("d_outputs", f_taken, EXP_OUT);
        check("d_done_pulses", f_dones, 1);
        check("d_first_valid_px", f_first, 15);

        to_neg();
        to_drive();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
